demux2_stream: RTL
==================

Name: demux2_stream

Overview:
- Multibit 1-to-2 stream demultiplexer: the fan-out counterpart of the team's 2-input MUX in the NYQ datapath.
- It routes one valid/ready input stream to one of two output streams, chosen per beat by a select bit.
- Each output has a registered slice, giving 1-cycle latency, full throughput and no combinational path between the two outputs.
- It sits wherever one NYQ producer feeds two alternate consumers.

Parameters:
- WIDTH, 16, data width in bits of the input and of both outputs.
- CNT_WIDTH, 16, width of the per-port beat counters (used only with DEMUX2_CNT_EN).

Ports:
- Clk_CI  input  1  clock; all flops on the rising edge.
- Rst_RBI  input  1  reset, asynchronous, active-low.
- In_DI  input  WIDTH  input data beat.
- InValid_SI  input  1  input beat valid.
- InSel_SI  input  1  destination of the current beat (0: port 0, 1: port 1); qualified by InValid_SI.
- InReady_SO  output  1  input beat accepted when InValid_SI and InReady_SO are both high.
- Out0_DO  output  WIDTH  port-0 data.
- Out0Valid_SO  output  1  port-0 valid.
- Out0Ready_SI  input  1  port-0 downstream ready.
- Out1_DO  output  WIDTH  port-1 data.
- Out1Valid_SO  output  1  port-1 valid.
- Out1Ready_SI  input  1  port-1 downstream ready.
- CntClr_SI  input  1  synchronous counter clear (DEMUX2_CNT_EN only).
- Cnt0_DO  output  CNT_WIDTH  port-0 delivered-beat count (DEMUX2_CNT_EN only).
- Cnt1_DO  output  CNT_WIDTH  port-1 delivered-beat count (DEMUX2_CNT_EN only).

Behaviour:
- Reset (Rst_RBI low, asynchronous): Out0/Out1 data = 0, Out0Valid_SO = Out1Valid_SO = 0, counters = 0, InReady_SO = 0 (forced low while reset is asserted).
- Slot k is free when OutkValid_SO = 0 or OutkReady_SI = 1.
- InReady_SO = (InSel_SI ? slot1 free : slot0 free), combinational. It is independent of InValid_SI and of the unselected port.
- Accept (InValid_SI & InReady_SO): In_DI is registered into the selected slot and its valid is set. The beat appears at the output on the next cycle (latency 1).
- Output handshake (OutkValid & OutkReady): slot k empties unless a new beat is loaded in the same cycle. Load wins, so back-to-back beats give 1 beat per cycle per port.
- Unselected slot: data and valid hold; a pending handshake on it still completes normally.
- Both outputs may drain in the same cycle as an accept to either port.
- Ordering: beats to the same port keep input order. No ordering guarantee across ports.
- Input protocol rules:
  - Once InValid_SI is high, In_DI and InSel_SI must stay stable until accepted.
  - InValid_SI must not drop before acceptance.
  - The bench asserts these rules; the RTL does not check them.
- Output protocol: OutkValid_SO, once high, stays high with Outk_DO stable until OutkReady_SI.
- Backpressure: a stalled port blocks only beats selected to it. Beats to the other port still flow.
- Reset mid-transfer: pending beats in both slots are discarded with no output handshake.

Optional Feature:
- Macro DEMUX2_CNT_EN.
- Defined:
  - Cnt0_DO and Cnt1_DO count output handshakes on their port.
  - Counters saturate at all-ones and do not wrap.
  - CntClr_SI zeroes both counters on the next edge; clear has priority over an increment in the same cycle.
  - Ports CntClr_SI, Cnt0_DO and Cnt1_DO exist.
- Undefined: counter logic and those three ports are absent; all other behaviour is identical.

Decomposition:
- Package nyq_pkg holds the default WIDTH and CNT_WIDTH constants and a port-select typedef (1-bit enum PORT0/PORT1).
- One sub-module, stream_reg_slice: a single-entry valid/ready register stage with a load-while-drain bypass, parameterised by WIDTH. It is instantiated twice.
- Counters live inline in the top level, inside the DEMUX2_CNT_EN guard.

Test Plan:
- Reset: hold Rst_RBI low, drive InValid_SI=1 -> InReady_SO=0, both valids 0. Release -> InReady_SO=1 on the first edge.
- Streaming: 8 beats 0x0001..0x0008, InSel alternating 0/1, both readies high -> port 0 gets 0x0001,0x0003,0x0005,0x0007 and port 1 gets 0x0002,0x0004,0x0006,0x0008, each 1 cycle after accept, no bubbles.
- Isolation: Out0Ready_SI=0 with a beat 0xAAAA held in slot 0, then a beat 0x1234 with InSel=0 -> InReady_SO=0, 0xAAAA stable. Switch the next beat to InSel=1 with 0x5555 -> accepted, appears on Out1_DO next cycle.
- Load-while-drain: slot 1 full with 0x00FF, Out1Ready_SI=1, input beat 0x0F0F with InSel=1 in the same cycle -> Out1 shows 0x0F0F next cycle, valid stays high, no lost beat.
- Reset mid-operation: both slots full, assert Rst_RBI for 1 cycle -> both valids drop immediately and nothing is delivered afterwards.
- DEMUX2_CNT_EN: CNT_WIDTH=4, 20 beats to port 0 -> Cnt0_DO=0xF (saturated), Cnt1_DO=0. Pulse CntClr_SI together with a port-0 handshake -> Cnt0_DO=0.

Source files
------------

// File: rtl/nyq_pkg.sv
// Shared NYQ datapath constants and the port-select type used by demux2_stream.
package nyq_pkg;

   localparam int WIDTH_DEF     = 16;
   localparam int CNT_WIDTH_DEF = 16;

   typedef enum logic {
      PORT0 = 1'b0,
      PORT1 = 1'b1
   } port_sel_e;

endpackage

// File: rtl/stream_reg_slice.sv
// Single-entry valid/ready register stage. A load in the same cycle as an
// output handshake replaces the drained beat, giving one beat per cycle.
module stream_reg_slice #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load,
   output logic             free,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   input  logic             ready
);

   // Free when empty or when the held beat leaves on this edge.
   assign free = !valid || ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data  <= '0;
         valid <= 1'b0;
      end else if (load) begin
         data  <= load_data;
         valid <= 1'b1;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/demux2_stream.sv
// 1-to-2 valid/ready stream demultiplexer with a registered slice per output.
// Define DEMUX2_CNT_EN to add saturating per-port delivered-beat counters.
module demux2_stream
   import nyq_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
   input  logic                 Clk_CI,
   input  logic                 Rst_RBI,
   input  logic [WIDTH-1:0]     In_DI,
   input  logic                 InValid_SI,
   input  logic                 InSel_SI,
   output logic                 InReady_SO,
   output logic [WIDTH-1:0]     Out0_DO,
   output logic                 Out0Valid_SO,
   input  logic                 Out0Ready_SI,
   output logic [WIDTH-1:0]     Out1_DO,
   output logic                 Out1Valid_SO,
   input  logic                 Out1Ready_SI
`ifdef DEMUX2_CNT_EN
  ,input  logic                 CntClr_SI,
   output logic [CNT_WIDTH-1:0] Cnt0_DO,
   output logic [CNT_WIDTH-1:0] Cnt1_DO
`endif
);

   port_sel_e sel;
   logic      free0, free1;
   logic      accept, load0, load1;

   assign sel = port_sel_e'(InSel_SI);

   // Slices look free during reset, so ready is gated by reset explicitly.
   assign InReady_SO = Rst_RBI && ((sel == PORT1) ? free1 : free0);
   assign accept     = InValid_SI && InReady_SO;
   assign load0      = accept && (sel == PORT0);
   assign load1      = accept && (sel == PORT1);

   stream_reg_slice #(.WIDTH(WIDTH)) u_slice0 (
      .clk       (Clk_CI),
      .rst_n     (Rst_RBI),
      .load_data (In_DI),
      .load      (load0),
      .free      (free0),
      .data      (Out0_DO),
      .valid     (Out0Valid_SO),
      .ready     (Out0Ready_SI)
   );

   stream_reg_slice #(.WIDTH(WIDTH)) u_slice1 (
      .clk       (Clk_CI),
      .rst_n     (Rst_RBI),
      .load_data (In_DI),
      .load      (load1),
      .free      (free1),
      .data      (Out1_DO),
      .valid     (Out1Valid_SO),
      .ready     (Out1Ready_SI)
   );

`ifdef DEMUX2_CNT_EN
   logic fire0, fire1;

   assign fire0 = Out0Valid_SO && Out0Ready_SI;
   assign fire1 = Out1Valid_SO && Out1Ready_SI;

   // Clear beats increment; counts stick at all-ones.
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         Cnt0_DO <= '0;
         Cnt1_DO <= '0;
      end else if (CntClr_SI) begin
         Cnt0_DO <= '0;
         Cnt1_DO <= '0;
      end else begin
         if (fire0 && (Cnt0_DO != '1)) Cnt0_DO <= Cnt0_DO + 1'b1;
         if (fire1 && (Cnt1_DO != '1)) Cnt1_DO <= Cnt1_DO + 1'b1;
      end
   end
`endif

endmodule
